// File: rtl/voting_panel_ctrl.sv
// voting_panel_ctrl
// Front-panel controller for the voting machine. Raw asynchronous candidate
// buttons are synchronised, debounced and edge-detected, then an FSM accepts
// exactly one vote per press-and-release cycle. It also keeps saturating
// per-candidate counters, tracks the leader and drives a selectable display
// bus.
module voting_panel_ctrl #(
   parameter int N_CAND       = 4,
   parameter int CNT_W        = 8,
   parameter int DEBOUNCE_CYC = 16,
   parameter int FLASH_CYC    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    admin_mode,
   input  logic                    clear_cnt,
   input  logic [N_CAND-1:0]       btn,
   input  logic [2:0]              sel,
   output logic [N_CAND*CNT_W-1:0] count_bus,
   output logic [CNT_W-1:0]        disp,
   output logic                    valid_vote,
   output logic                    invalid_vote,
   output logic [2:0]              winner,
   output logic                    tie,
   output logic                    overflow,
   output logic                    vote_flash,
   output logic [1:0]              state_out
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ARMED  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;
   localparam logic [1:0] S_ADMIN  = 2'd3;

   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int FL_W = $clog2(FLASH_CYC + 2);

   // Counter increment that sticks at the all-ones value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Status word {overflow, tie, state, winner}, zero-padded or truncated
   // to the display width.
   function automatic logic [CNT_W-1:0] fit_status(input logic [6:0] s);
      return CNT_W'(s);
   endfunction

   logic [1:0]        state, state_nxt;
   logic [N_CAND-1:0] btn_sync_p0, btn_sync_p1;
   logic [N_CAND-1:0] btn_deb_p2, btn_deb_p3;
   logic [DB_W-1:0]   db_cnt [N_CAND];
   logic [N_CAND-1:0] press;
   logic [2:0]        n_press;
   logic              others_high;
   logic              accept, reject;
   logic [CNT_W-1:0]  cnt [N_CAND];
   logic [CNT_W-1:0]  lead_max;
   logic [2:0]        lead_idx;
   logic [2:0]        n_max;
   logic [FL_W-1:0]   fl_cnt;

   // ---- stage p0/p1: two-flop synchroniser on the raw pins ----
   // Bring the asynchronous buttons into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_sync_p0 <= '0;
         btn_sync_p1 <= '0;
      end else begin
         btn_sync_p0 <= btn;
         btn_sync_p1 <= btn_sync_p0;
      end
   end

   // ---- stage p2: debounced level, p3: its previous value ----
   // Flip the debounced level only after DEBOUNCE_CYC consecutive mismatches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_deb_p2 <= '0;
         btn_deb_p3 <= '0;
         for (int i = 0; i < N_CAND; i++) db_cnt[i] <= '0;
      end else begin
         btn_deb_p3 <= btn_deb_p2;
         for (int i = 0; i < N_CAND; i++) begin
            if (btn_sync_p1[i] != btn_deb_p2[i]) begin
               if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                  btn_deb_p2[i] <= ~btn_deb_p2[i];
                  db_cnt[i]     <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign press = btn_deb_p2 & ~btn_deb_p3;

   // Count new presses and detect any other button already held down.
   always_comb begin
      n_press = '0;
      for (int i = 0; i < N_CAND; i++) n_press = n_press + 3'(press[i]);
      others_high = |(btn_deb_p2 & ~press);
   end

   // A vote is judged only in ARMED; admin and disable take priority.
   assign accept = (state == S_ARMED) && enable && !admin_mode &&
                   (n_press == 3'd1) && !others_high;
   assign reject = (state == S_ARMED) && enable && !admin_mode &&
                   (press != '0) && ((n_press > 3'd1) || others_high);

   // Next-state selection with admin over disable over normal flow.
   always_comb begin
      state_nxt = state;
      if (admin_mode) begin
         state_nxt = S_ADMIN;
      end else if (!enable) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   state_nxt = S_ARMED;
            S_ARMED:  if (accept || reject) state_nxt = S_LOCKED;
            S_LOCKED: if (btn_deb_p2 == '0) state_nxt = S_ARMED;
            S_ADMIN:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   // ---- decision stage: state, pulses and counters share one edge ----
   // Register FSM state and the one-cycle accept/reject pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         valid_vote   <= 1'b0;
         invalid_vote <= 1'b0;
      end else begin
         state        <= state_nxt;
         valid_vote   <= accept;
         invalid_vote <= reject;
      end
   end

   // Saturating vote counters with sticky overflow and admin clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CAND; i++) cnt[i] <= '0;
         overflow <= 1'b0;
      end else if ((state == S_ADMIN) && clear_cnt) begin
         for (int i = 0; i < N_CAND; i++) cnt[i] <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         for (int i = 0; i < N_CAND; i++) begin
            if (press[i]) begin
               cnt[i] <= sat_inc(cnt[i]);
               if (&cnt[i]) overflow <= 1'b1;
            end
         end
      end
   end

   // Find the maximum count, its lowest index and how many share it.
   always_comb begin
      lead_max = cnt[0];
      lead_idx = '0;
      for (int i = 1; i < N_CAND; i++) begin
         if (cnt[i] > lead_max) begin
            lead_max = cnt[i];
            lead_idx = 3'(i);
         end
      end
      n_max = '0;
      for (int i = 0; i < N_CAND; i++) begin
         if (cnt[i] == lead_max) n_max = n_max + 3'd1;
      end
   end

   // ---- leader stage: one cycle behind the counters ----
   // Register winner and tie; all-zero counts read as a tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         winner <= '0;
         tie    <= 1'b1;
      end else begin
         winner <= lead_idx;
         tie    <= (n_max > 3'd1) || (lead_max == '0);
      end
   end

   // Stretch each accepted vote into a FLASH_CYC-long indicator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fl_cnt <= '0;
      end else if (accept) begin
         fl_cnt <= FL_W'(FLASH_CYC);
      end else if (fl_cnt != '0) begin
         fl_cnt <= fl_cnt - 1'b1;
      end
   end

   assign vote_flash = (fl_cnt != '0);
   assign state_out  = state;

   // Flatten the counter array onto the output bus.
   always_comb begin
      count_bus = '0;
      for (int i = 0; i < N_CAND; i++) count_bus[i*CNT_W +: CNT_W] = cnt[i];
   end

   // Display mux: a counter, the status word, or zero.
   always_comb begin
      disp = '0;
      for (int i = 0; i < N_CAND; i++) begin
         if (sel == 3'(i)) disp = cnt[i];
      end
      if (sel == 3'(N_CAND)) disp = fit_status({overflow, tie, state, winner});
   end

endmodule

// File: tb/tb_voting_panel_ctrl.sv
// tb_voting_panel_ctrl
// Drives two voting_panel_ctrl instances (8-bit and 3-bit counters) from the
// same pins and compares them against a vote-tally reference model.
module tb_voting_panel_ctrl;

   localparam int N   = 4;
   localparam int DEB = 4;
   localparam int FL  = 8;
   localparam int WA  = 8;
   localparam int WB  = 3;

   logic clk = 1'b0;
   logic rst, enable, admin_mode, clear_cnt;
   logic [N-1:0] btn;
   logic [2:0] sel;

   logic [N*WA-1:0] bus_a;
   logic [WA-1:0] disp_a;
   logic valid_a, invalid_a, tie_a, ovf_a, flash_a;
   logic [2:0] win_a;
   logic [1:0] state_a;

   logic [N*WB-1:0] bus_b;
   logic [WB-1:0] disp_b;
   logic valid_b, invalid_b, tie_b, ovf_b, flash_b;
   logic [2:0] win_b;
   logic [1:0] state_b;

   voting_panel_ctrl #(.N_CAND(N), .CNT_W(WA), .DEBOUNCE_CYC(DEB), .FLASH_CYC(FL)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .admin_mode(admin_mode),
      .clear_cnt(clear_cnt), .btn(btn), .sel(sel), .count_bus(bus_a),
      .disp(disp_a), .valid_vote(valid_a), .invalid_vote(invalid_a),
      .winner(win_a), .tie(tie_a), .overflow(ovf_a), .vote_flash(flash_a),
      .state_out(state_a));

   voting_panel_ctrl #(.N_CAND(N), .CNT_W(WB), .DEBOUNCE_CYC(DEB), .FLASH_CYC(FL)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .admin_mode(admin_mode),
      .clear_cnt(clear_cnt), .btn(btn), .sel(sel), .count_bus(bus_b),
      .disp(disp_b), .valid_vote(valid_b), .invalid_vote(invalid_b),
      .winner(win_b), .tie(tie_b), .overflow(ovf_b), .vote_flash(flash_b),
      .state_out(state_b));

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: total accepted votes per candidate since last clear.
   int votes[N];

   // Observation record filled by run().
   int n_valid, n_invalid, n_valid_b, n_invalid_b;
   int first_valid, first_invalid, edge_idx, flash_hi;
   logic [2:0] win_after;
   logic tie_after, flash_at_valid;
   logic [1:0] st_at_valid, st_hold, st_last;

   function automatic int ecnt(int i, int w);
      int mx = (1 << w) - 1;
      return (votes[i] > mx) ? mx : votes[i];
   endfunction

   function automatic int ewin(int w);
      int best = 0;
      for (int i = 1; i < N; i++) if (ecnt(i, w) > ecnt(best, w)) best = i;
      return best;
   endfunction

   function automatic bit etie(int w);
      int m = ecnt(ewin(w), w);
      int k = 0;
      for (int i = 0; i < N; i++) if (ecnt(i, w) == m) k++;
      return (k >= 2) || (m == 0);
   endfunction

   function automatic bit eovf(int w);
      bit o = 0;
      for (int i = 0; i < N; i++) if (votes[i] > (1 << w) - 1) o = 1;
      return o;
   endfunction

   function automatic logic [N*WA-1:0] ebus_a();
      logic [N*WA-1:0] r = '0;
      for (int i = 0; i < N; i++) r[i*WA +: WA] = WA'(ecnt(i, WA));
      return r;
   endfunction

   function automatic logic [N*WB-1:0] ebus_b();
      logic [N*WB-1:0] r = '0;
      for (int i = 0; i < N; i++) r[i*WB +: WB] = WB'(ecnt(i, WB));
      return r;
   endfunction

   task automatic clr_stats();
      n_valid = 0; n_invalid = 0; n_valid_b = 0; n_invalid_b = 0;
      first_valid = 0; first_invalid = 0; edge_idx = 0; flash_hi = 0;
      win_after = '0; tie_after = 1'b0; flash_at_valid = 1'b0;
      st_at_valid = '0; st_hold = '0; st_last = '0;
   endtask

   // Advance n edges, sampling 1 time unit after each rising edge.
   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         edge_idx++;
         if (valid_a) begin
            n_valid++;
            if (first_valid == 0) begin
               first_valid = edge_idx;
               flash_at_valid = flash_a;
               st_at_valid = state_a;
            end
         end
         if (invalid_a) begin
            n_invalid++;
            if (first_invalid == 0) first_invalid = edge_idx;
         end
         if (valid_b) n_valid_b++;
         if (invalid_b) n_invalid_b++;
         if (first_valid != 0 && edge_idx == first_valid + 1) begin
            win_after = win_a;
            tie_after = tie_a;
         end
         if (flash_a) flash_hi++;
         st_last = state_a;
      end
   endtask

   task automatic push(input logic [N-1:0] mask, input int hold, input int rel);
      clr_stats();
      btn = mask;
      run(hold);
      st_hold = state_a;
      btn = '0;
      run(rel);
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; admin_mode = 1'b0; clear_cnt = 1'b0;
      btn = '0; sel = 3'd0;
      for (int i = 0; i < N; i++) votes[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++; if (state_a !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", state_a); end
      tests_run++; if (valid_a !== 1'b0 || invalid_a !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got %b%b want 00", valid_a, invalid_a); end
      tests_run++; if (win_a !== 3'd0 || tie_a !== 1'b1) begin tests_failed++; $display("FAIL reset_leader: got win=%0d tie=%b want 0/1", win_a, tie_a); end
      tests_run++; if (ovf_a !== 1'b0 || flash_a !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got ovf=%b flash=%b want 0/0", ovf_a, flash_a); end
      tests_run++; if (bus_a !== '0 || bus_b !== '0 || disp_a !== '0) begin tests_failed++; $display("FAIL reset_counts: got %0h/%0h disp=%0h want 0", bus_a, bus_b, disp_a); end
      rst = 1'b0;
      enable = 1'b1;
      clr_stats();
      run(1);
      tests_run++; if (state_a !== 2'd1) begin tests_failed++; $display("FAIL reset_to_armed: got %0d want 1", state_a); end
   endtask

   task automatic test_clean_vote();
      push(4'b0100, 10, 12);
      votes[2]++;
      tests_run++; if (first_valid !== DEB + 3) begin tests_failed++; $display("FAIL clean_latency: got edge %0d want %0d", first_valid, DEB + 3); end
      tests_run++; if (n_valid !== 1 || n_invalid !== 0 || n_valid_b !== 1) begin tests_failed++; $display("FAIL clean_pulses: got v=%0d i=%0d vb=%0d want 1/0/1", n_valid, n_invalid, n_valid_b); end
      tests_run++; if (st_at_valid !== 2'd2) begin tests_failed++; $display("FAIL clean_locked: got %0d want 2", st_at_valid); end
      tests_run++; if (win_after !== 3'd2 || tie_after !== 1'b0) begin tests_failed++; $display("FAIL clean_leader: got win=%0d tie=%b want 2/0", win_after, tie_after); end
      tests_run++; if (flash_at_valid !== 1'b1 || flash_hi !== FL) begin tests_failed++; $display("FAIL clean_flash: got start=%b cycles=%0d want 1/%0d", flash_at_valid, flash_hi, FL); end
      tests_run++; if (st_last !== 2'd1) begin tests_failed++; $display("FAIL clean_rearm: got %0d want 1", st_last); end
      tests_run++; if (bus_a !== ebus_a() || bus_b !== ebus_b()) begin tests_failed++; $display("FAIL clean_counts: got %0h/%0h want %0h/%0h", bus_a, bus_b, ebus_a(), ebus_b()); end
   endtask

   task automatic test_glitch();
      for (int k = 0; k < 3; k++) begin
         int c = $urandom_range(0, N - 1);
         int h = $urandom_range(1, DEB - 1);
         push(N'(1 << c), h, 12);
         tests_run++; if (n_valid !== 0 || n_invalid !== 0) begin tests_failed++; $display("FAIL glitch_pulse: btn%0d len %0d got v=%0d i=%0d want 0/0", c, h, n_valid, n_invalid); end
         tests_run++; if (bus_a !== ebus_a()) begin tests_failed++; $display("FAIL glitch_counts: got %0h want %0h", bus_a, ebus_a()); end
      end
      push(4'b0010, DEB, 12);
      votes[1]++;
      tests_run++; if (n_valid !== 1 || bus_a !== ebus_a()) begin tests_failed++; $display("FAIL glitch_min_hold: got v=%0d bus=%0h want 1/%0h", n_valid, bus_a, ebus_a()); end
   endtask

   task automatic test_simultaneous();
      clr_stats();
      btn = 4'b1001;
      run(10);
      tests_run++; if (n_invalid !== 1 || n_valid !== 0 || first_invalid !== DEB + 3) begin tests_failed++; $display("FAIL simul_pulse: got i=%0d v=%0d at %0d want 1/0/%0d", n_invalid, n_valid, first_invalid, DEB + 3); end
      tests_run++; if (state_a !== 2'd2) begin tests_failed++; $display("FAIL simul_locked: got %0d want 2", state_a); end
      btn = 4'b1000;
      run(12);
      tests_run++; if (state_a !== 2'd2) begin tests_failed++; $display("FAIL simul_partial_release: got %0d want 2", state_a); end
      btn = 4'b0000;
      run(12);
      tests_run++; if (state_a !== 2'd1) begin tests_failed++; $display("FAIL simul_rearm: got %0d want 1", state_a); end
      tests_run++; if (bus_a !== ebus_a() || n_valid !== 0) begin tests_failed++; $display("FAIL simul_counts: got %0h v=%0d want %0h/0", bus_a, n_valid, ebus_a()); end
   endtask

   task automatic test_held_then_press();
      enable = 1'b0;
      clr_stats();
      btn = 4'b0001;
      run(12);
      tests_run++; if (n_valid !== 0 || n_invalid !== 0 || state_a !== 2'd0) begin tests_failed++; $display("FAIL disabled_press: got v=%0d i=%0d st=%0d want 0/0/0", n_valid, n_invalid, state_a); end
      enable = 1'b1;
      run(1);
      tests_run++; if (state_a !== 2'd1) begin tests_failed++; $display("FAIL enable_arm: got %0d want 1", state_a); end
      clr_stats();
      btn = 4'b0011;
      run(12);
      tests_run++; if (n_invalid !== 1 || n_valid !== 0 || state_a !== 2'd2) begin tests_failed++; $display("FAIL held_press: got i=%0d v=%0d st=%0d want 1/0/2", n_invalid, n_valid, state_a); end
      btn = 4'b0000;
      run(12);
      tests_run++; if (state_a !== 2'd1 || bus_a !== ebus_a()) begin tests_failed++; $display("FAIL held_release: got st=%0d bus=%0h want 1/%0h", state_a, bus_a, ebus_a()); end
   endtask

   task automatic test_saturation();
      while (votes[1] < (1 << WB)) begin
         push(4'b0010, 8, 12);
         votes[1]++;
      end
      tests_run++; if (n_valid !== 1 || n_valid_b !== 1) begin tests_failed++; $display("FAIL sat_valid: got v=%0d vb=%0d want 1/1", n_valid, n_valid_b); end
      tests_run++; if (bus_b[WB +: WB] !== 3'd7 || bus_b !== ebus_b()) begin tests_failed++; $display("FAIL sat_hold: got %0h want %0h", bus_b, ebus_b()); end
      tests_run++; if (ovf_b !== 1'b1 || ovf_a !== 1'b0) begin tests_failed++; $display("FAIL sat_overflow: got b=%b a=%b want 1/0", ovf_b, ovf_a); end
      tests_run++; if (bus_a !== ebus_a()) begin tests_failed++; $display("FAIL sat_wide: got %0h want %0h", bus_a, ebus_a()); end
      admin_mode = 1'b1;
      clr_stats();
      run(1);
      tests_run++; if (state_a !== 2'd3) begin tests_failed++; $display("FAIL admin_enter: got %0d want 3", state_a); end
      btn = 4'b0100;
      run(12);
      btn = 4'b0000;
      run(12);
      tests_run++; if (n_valid !== 0 || n_invalid !== 0 || bus_a !== ebus_a()) begin tests_failed++; $display("FAIL admin_ignore: got v=%0d i=%0d bus=%0h", n_valid, n_invalid, bus_a); end
      clear_cnt = 1'b1;
      run(1);
      for (int i = 0; i < N; i++) votes[i] = 0;
      tests_run++; if (bus_a !== '0 || bus_b !== '0 || ovf_b !== 1'b0) begin tests_failed++; $display("FAIL admin_clear: got %0h/%0h ovf=%b want 0/0/0", bus_a, bus_b, ovf_b); end
      clear_cnt = 1'b0;
      run(1);
      tests_run++; if (tie_a !== 1'b1 || tie_b !== 1'b1 || win_a !== 3'd0) begin tests_failed++; $display("FAIL admin_tie: got tie=%b/%b win=%0d want 1/1/0", tie_a, tie_b, win_a); end
      admin_mode = 1'b0;
      run(1);
      tests_run++; if (state_a !== 2'd0) begin tests_failed++; $display("FAIL admin_exit: got %0d want 0", state_a); end
      run(1);
   endtask

   task automatic test_tie_disp();
      int order[4] = '{0, 0, 3, 3};
      logic [WA-1:0] status;
      for (int i = 3; i > 0; i--) begin
         int j = $urandom_range(0, i);
         int t = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      for (int k = 0; k < 4; k++) begin
         push(N'(1 << order[k]), 8, 12);
         votes[order[k]]++;
      end
      tests_run++; if (win_a !== 3'(ewin(WA)) || tie_a !== etie(WA)) begin tests_failed++; $display("FAIL tie_leader: got win=%0d tie=%b want %0d/%b", win_a, tie_a, ewin(WA), etie(WA)); end
      tests_run++; if (bus_a !== ebus_a()) begin tests_failed++; $display("FAIL tie_counts: got %0h want %0h", bus_a, ebus_a()); end
      status = {1'b0, eovf(WA), etie(WA), 2'd1, 3'(ewin(WA))};
      sel = 3'd4;
      #1;
      tests_run++; if (disp_a !== status || disp_a[5] !== 1'b1) begin tests_failed++; $display("FAIL disp_status: got %0h want %0h", disp_a, status); end
      tests_run++; if (disp_b !== 3'(ewin(WB))) begin tests_failed++; $display("FAIL disp_status_trunc: got %0h want %0h", disp_b, ewin(WB)); end
      sel = 3'd5;
      #1;
      tests_run++; if (disp_a !== '0 || disp_b !== '0) begin tests_failed++; $display("FAIL disp_beyond: got %0h/%0h want 0", disp_a, disp_b); end
      sel = 3'd3;
      #1;
      tests_run++; if (disp_a !== WA'(ecnt(3, WA))) begin tests_failed++; $display("FAIL disp_count3: got %0h want %0h", disp_a, ecnt(3, WA)); end
      sel = 3'd0;
      #1;
      tests_run++; if (disp_a !== WA'(ecnt(0, WA))) begin tests_failed++; $display("FAIL disp_count0: got %0h want %0h", disp_a, ecnt(0, WA)); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 20; k++) begin
         logic [N-1:0] mask = N'($urandom_range(1, (1 << N) - 1));
         int h = $urandom_range(1, 12);
         int ev = 0;
         int ei = 0;
         if (h >= DEB) begin
            if ($countones(mask) == 1) begin
               ev = 1;
               for (int i = 0; i < N; i++) if (mask[i]) votes[i]++;
            end else begin
               ei = 1;
            end
         end
         push(mask, h, 12);
         tests_run++; if (n_valid !== ev || n_invalid !== ei || n_valid_b !== ev || n_invalid_b !== ei) begin tests_failed++; $display("FAIL rand_pulse: mask=%b hold=%0d got v=%0d i=%0d want %0d/%0d", mask, h, n_valid, n_invalid, ev, ei); end
         tests_run++; if (bus_a !== ebus_a() || bus_b !== ebus_b()) begin tests_failed++; $display("FAIL rand_counts: got %0h/%0h want %0h/%0h", bus_a, bus_b, ebus_a(), ebus_b()); end
         tests_run++; if (win_a !== 3'(ewin(WA)) || tie_a !== etie(WA) || win_b !== 3'(ewin(WB)) || tie_b !== etie(WB)) begin tests_failed++; $display("FAIL rand_leader: got %0d%b/%0d%b want %0d%b/%0d%b", win_a, tie_a, win_b, tie_b, ewin(WA), etie(WA), ewin(WB), etie(WB)); end
         tests_run++; if (ovf_a !== eovf(WA) || ovf_b !== eovf(WB) || state_a !== 2'd1) begin tests_failed++; $display("FAIL rand_flags: got ovf=%b/%b st=%0d want %b/%b/1", ovf_a, ovf_b, state_a, eovf(WA), eovf(WB)); end
      end
   endtask

   task automatic test_reset_mid();
      clr_stats();
      btn = 4'b0100;
      run(DEB + 4);
      tests_run++; if (state_a !== 2'd2 || flash_a !== 1'b1) begin tests_failed++; $display("FAIL mid_precondition: got st=%0d flash=%b want 2/1", state_a, flash_a); end
      #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < N; i++) votes[i] = 0;
      tests_run++; if (state_a !== 2'd0 || flash_a !== 1'b0 || valid_a !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_ctrl: got st=%0d flash=%b v=%b want 0/0/0", state_a, flash_a, valid_a); end
      tests_run++; if (bus_a !== '0 || bus_b !== '0 || ovf_b !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_counts: got %0h/%0h ovf=%b want 0", bus_a, bus_b, ovf_b); end
      tests_run++; if (win_a !== 3'd0 || tie_a !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_leader: got win=%0d tie=%b want 0/1", win_a, tie_a); end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr_stats();
      run(14);
      votes[2]++;
      tests_run++; if (n_valid !== 1 || first_valid !== DEB + 3) begin tests_failed++; $display("FAIL mid_fresh_press: got v=%0d at %0d want 1/%0d", n_valid, first_valid, DEB + 3); end
      btn = 4'b0000;
      run(12);
      tests_run++; if (bus_a !== ebus_a() || state_a !== 2'd1) begin tests_failed++; $display("FAIL mid_after: got %0h st=%0d want %0h/1", bus_a, state_a, ebus_a()); end
   endtask

   initial begin
      test_reset();
      test_clean_vote();
      test_glitch();
      test_simultaneous();
      test_held_then_press();
      test_saturation();
      test_tie_disp();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
